// File: rtl/odd_result_pipe.sv
// -----------------------------------------------------------------------------
// odd_result_pipe
//
// Result delay line behind the odd pipe (permute, load/store, branch units).
// Every result packet enters stage 1 and moves one stage per clock until it
// retires from stage DEPTH.
//
// A packet is captured on edge N. It sits in stage k after edge N+k-1, and it
// drives the writeback port while it is in stage DEPTH.
//
// The producing unit's latency, stored with the packet, sets the first stage
// from which the value may be forwarded to the issue stage.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   in_wrt_en             incoming packet valid (writes a register)
//   in_rt_address         destination register of the incoming packet
//   in_value              128-bit result data
//   in_latency            producing unit latency (0 treated as 1, clamped to DEPTH)
//   flush                 branch redirect, kills stages 1..FLUSH_STAGES
//   q_r{a,b,c}_addr       operand lookup addresses
//   q_r{a,b,c}_hit        youngest match is ready, value forwarded
//   q_r{a,b,c}_value      forwarded data, 0 without a hit
//   q_r{a,b,c}_pending    youngest match not ready yet, issue must stall
//   wb_en/rt_address/value  register-file writeback from stage DEPTH
// -----------------------------------------------------------------------------
module odd_result_pipe #(
  parameter int DEPTH        = 7,
  parameter int FLUSH_STAGES = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_wrt_en,
  input  logic [6:0]   in_rt_address,
  input  logic [127:0] in_value,
  input  logic [2:0]   in_latency,
  input  logic         flush,
  input  logic [6:0]   q_ra_addr,
  input  logic [6:0]   q_rb_addr,
  input  logic [6:0]   q_rc_addr,
  output logic         q_ra_hit,
  output logic         q_rb_hit,
  output logic         q_rc_hit,
  output logic [127:0] q_ra_value,
  output logic [127:0] q_rb_value,
  output logic [127:0] q_rc_value,
  output logic         q_ra_pending,
  output logic         q_rb_pending,
  output logic         q_rc_pending,
  output logic         wb_en,
  output logic [6:0]   wb_rt_address,
  output logic [127:0] wb_value
);

  // The stored latency is 3 bits wide, so at most 7 stages can be addressed.
  localparam logic [2:0] DEPTH_L = 3'(DEPTH);
  localparam int         NQ      = 3;

  // ---------------------------------------------------------------------------
  // Delay-line storage, stage 1 (youngest) .. DEPTH (oldest)
  // ---------------------------------------------------------------------------
  logic         r_valid [1:DEPTH];
  logic [6:0]   r_rt    [1:DEPTH];
  logic [127:0] r_value [1:DEPTH];
  logic [2:0]   r_lat   [1:DEPTH];

  logic [2:0]   w_lat_norm;
  logic         w_kill_s1;
  logic         w_ready [1:DEPTH];

  // Latency normalisation at capture.
  always_comb begin
    if (in_latency == 3'd0) begin
      w_lat_norm = 3'd1;
    end else if (in_latency > DEPTH_L) begin
      w_lat_norm = DEPTH_L;
    end else begin
      w_lat_norm = in_latency;
    end
  end

  assign w_kill_s1 = flush && (FLUSH_STAGES >= 1);

  // The pipe never stalls. On a flush, only the valid bits of the young stages
  // are cleared; their data fields may shift in, but they are never observed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 1; s <= DEPTH; s++) begin
        r_valid[s] <= 1'b0;
        r_rt[s]    <= '0;
        r_value[s] <= '0;
        r_lat[s]   <= '0;
      end
    end else begin
      r_valid[1] <= in_wrt_en && !w_kill_s1;
      r_rt[1]    <= in_rt_address;
      r_value[1] <= in_value;
      r_lat[1]   <= w_lat_norm;
      for (int s = 2; s <= DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1] && !(flush && (s <= FLUSH_STAGES));
        r_rt[s]    <= r_rt[s-1];
        r_value[s] <= r_value[s-1];
        r_lat[s]   <= r_lat[s-1];
      end
    end
  end

  // An entry becomes forwardable once its stage number reaches its latency.
  always_comb begin
    for (int s = 1; s <= DEPTH; s++) begin
      w_ready[s] = (3'(s) >= r_lat[s]);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand forwarding. The first match found from stage 1 upward decides the
  // result. An older ready copy behind an unready younger one is stale data,
  // so that case reports pending rather than a hit.
  // ---------------------------------------------------------------------------
  logic [6:0]   w_q_addr  [NQ];
  logic         w_q_hit   [NQ];
  logic         w_q_pend  [NQ];
  logic [127:0] w_q_value [NQ];
  logic         w_q_found [NQ];

  assign w_q_addr[0] = q_ra_addr;
  assign w_q_addr[1] = q_rb_addr;
  assign w_q_addr[2] = q_rc_addr;

  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      w_q_hit[q]   = 1'b0;
      w_q_pend[q]  = 1'b0;
      w_q_value[q] = '0;
      w_q_found[q] = 1'b0;
      for (int s = 1; s <= DEPTH; s++) begin
        if (!w_q_found[q] && r_valid[s] && (r_rt[s] == w_q_addr[q])) begin
          w_q_found[q] = 1'b1;
          if (w_ready[s]) begin
            w_q_hit[q]   = 1'b1;
            w_q_value[q] = r_value[s];
          end else begin
            w_q_pend[q] = 1'b1;
          end
        end
      end
    end
  end

  assign q_ra_hit     = w_q_hit[0];
  assign q_rb_hit     = w_q_hit[1];
  assign q_rc_hit     = w_q_hit[2];
  assign q_ra_value   = w_q_value[0];
  assign q_rb_value   = w_q_value[1];
  assign q_rc_value   = w_q_value[2];
  assign q_ra_pending = w_q_pend[0];
  assign q_rb_pending = w_q_pend[1];
  assign q_rc_pending = w_q_pend[2];

  // ---------------------------------------------------------------------------
  // Writeback from the oldest stage. The outputs are gated to 0 when the stage
  // is empty, because flushed entries still carry data.
  // ---------------------------------------------------------------------------
  assign wb_en         = r_valid[DEPTH];
  assign wb_rt_address = r_valid[DEPTH] ? r_rt[DEPTH]    : 7'd0;
  assign wb_value      = r_valid[DEPTH] ? r_value[DEPTH] : 128'd0;

endmodule

// File: tb/tb_odd_result_pipe.sv
module tb_odd_result_pipe;

  localparam int DEPTH = 7;
  localparam int NCAP  = 4096;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_wrt_en = 1'b0;
  logic [6:0]   in_rt_address = '0;
  logic [127:0] in_value = '0;
  logic [2:0]   in_latency = '0;
  logic         flush = 1'b0;
  logic [6:0]   q_ra_addr = 7'd127;
  logic [6:0]   q_rb_addr = 7'd127;
  logic [6:0]   q_rc_addr = 7'd127;
  logic         q_ra_hit, q_rb_hit, q_rc_hit;
  logic [127:0] q_ra_value, q_rb_value, q_rc_value;
  logic         q_ra_pending, q_rb_pending, q_rc_pending;
  logic         wb_en;
  logic [6:0]   wb_rt_address;
  logic [127:0] wb_value;

  always #5 clock = ~clock;

  odd_result_pipe #(.DEPTH(DEPTH), .FLUSH_STAGES(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_wrt_en    (in_wrt_en),
    .in_rt_address(in_rt_address),
    .in_value     (in_value),
    .in_latency   (in_latency),
    .flush        (flush),
    .q_ra_addr    (q_ra_addr),
    .q_rb_addr    (q_rb_addr),
    .q_rc_addr    (q_rc_addr),
    .q_ra_hit     (q_ra_hit),
    .q_rb_hit     (q_rb_hit),
    .q_rc_hit     (q_rc_hit),
    .q_ra_value   (q_ra_value),
    .q_rb_value   (q_rb_value),
    .q_rc_value   (q_rc_value),
    .q_ra_pending (q_ra_pending),
    .q_rb_pending (q_rb_pending),
    .q_rc_pending (q_rc_pending),
    .wb_en        (wb_en),
    .wb_rt_address(wb_rt_address),
    .wb_value     (wb_value)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a log of every packet by the edge that captured it.
  // After edge T, stage k holds the packet from edge T-k+1, unless that packet
  // was flushed or captured before the most recent reset.
  // ---------------------------------------------------------------------------
  bit           cap_v   [NCAP];
  logic [6:0]   cap_rt  [NCAP];
  logic [127:0] cap_val [NCAP];
  int           cap_lat [NCAP];
  int           edge_cnt   = 0;
  int           reset_edge = 0;

  always @(posedge clock) begin
    if (reset) begin
      edge_cnt++;
      cap_v[edge_cnt]   = in_wrt_en && !flush;
      cap_rt[edge_cnt]  = in_rt_address;
      cap_val[edge_cnt] = in_value;
      cap_lat[edge_cnt] = (in_latency == 0) ? 1 : ((int'(in_latency) > DEPTH) ? DEPTH : int'(in_latency));
    end
  end

  always @(negedge reset) reset_edge = edge_cnt;

  function automatic bit live(input int e);
    return (e >= 1) && (e > reset_edge) && cap_v[e];
  endfunction

  task automatic model_fwd(input logic [6:0] a, output bit h, output logic [127:0] v, output bit p);
    h = 1'b0; v = '0; p = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      int e;
      e = edge_cnt - k + 1;
      if (live(e) && cap_rt[e] == a) begin
        if (k >= cap_lat[e]) begin
          h = 1'b1;
          v = cap_val[e];
        end else begin
          p = 1'b1;
        end
        break;
      end
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clock) begin : cmp
    bit           h, p;
    logic [127:0] v;
    int           e;
    e = edge_cnt - DEPTH + 1;
    if (live(e)) begin
      chk("m_wb_en", 128'(wb_en), 128'(1));
      chk("m_wb_rt", 128'(wb_rt_address), 128'(cap_rt[e]));
      chk("m_wb_value", wb_value, cap_val[e]);
    end else begin
      chk("m_wb_en", 128'(wb_en), 128'(0));
      chk("m_wb_rt", 128'(wb_rt_address), 128'(0));
      chk("m_wb_value", wb_value, 128'(0));
    end
    model_fwd(q_ra_addr, h, v, p);
    chk("m_ra_hit", 128'(q_ra_hit), 128'(h));
    chk("m_ra_value", q_ra_value, v);
    chk("m_ra_pending", 128'(q_ra_pending), 128'(p));
    model_fwd(q_rb_addr, h, v, p);
    chk("m_rb_hit", 128'(q_rb_hit), 128'(h));
    chk("m_rb_value", q_rb_value, v);
    chk("m_rb_pending", 128'(q_rb_pending), 128'(p));
    model_fwd(q_rc_addr, h, v, p);
    chk("m_rc_hit", 128'(q_rc_hit), 128'(h));
    chk("m_rc_value", q_rc_value, v);
    chk("m_rc_pending", 128'(q_rc_pending), 128'(p));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [6:0] rt, input logic [127:0] val, input logic [2:0] lat);
    in_wrt_en     = 1'b1;
    in_rt_address = rt;
    in_value      = val;
    in_latency    = lat;
  endtask

  initial begin
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_wb_en", 128'(wb_en), 128'(0));
    reset = 1'b1;

    // Basic writeback and readiness window, latency 4.
    send(7'd5, 128'hA5A5, 3'd4);
    q_ra_addr = 7'd5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      in_wrt_en = 1'b0;
      chk("t1_wb_en", 128'(wb_en), 128'(k == 7));
      if (k == 7) begin
        chk("t1_wb_rt", 128'(wb_rt_address), 128'd5);
        chk("t1_wb_value", wb_value, 128'hA5A5);
      end
      chk("t1_ra_pending", 128'(q_ra_pending), 128'(k <= 3));
      chk("t1_ra_hit", 128'(q_ra_hit), 128'(k >= 4 && k <= 7));
      chk("t1_ra_value", q_ra_value, (k >= 4 && k <= 7) ? 128'hA5A5 : 128'h0);
    end

    // Youngest match wins and blocks an older ready copy.
    q_rb_addr = 7'd9;
    send(7'd9, 128'h1, 3'd1);
    tick();
    chk("t2_old_hit", 128'(q_rb_hit), 128'd1);
    chk("t2_old_value", q_rb_value, 128'h1);
    send(7'd9, 128'h2, 3'd6);
    for (int k = 1; k <= 7; k++) begin
      tick();
      in_wrt_en = 1'b0;
      chk("t2_rb_pending", 128'(q_rb_pending), 128'(k <= 5));
      chk("t2_rb_hit", 128'(q_rb_hit), 128'(k >= 6));
      chk("t2_rb_value", q_rb_value, (k >= 6) ? 128'h2 : 128'h0);
    end
    tick();

    // Latency clamp: 0 is ready in stage 1, 7 only in stage 7.
    q_rc_addr = 7'd20;
    send(7'd20, 128'h20, 3'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      in_wrt_en = 1'b0;
      chk("t3_lat0_hit", 128'(q_rc_hit), 128'(k <= 7));
      chk("t3_lat0_pending", 128'(q_rc_pending), 128'(0));
    end
    q_rc_addr = 7'd21;
    send(7'd21, 128'h21, 3'd7);
    for (int k = 1; k <= 8; k++) begin
      tick();
      in_wrt_en = 1'b0;
      chk("t3_lat7_hit", 128'(q_rc_hit), 128'(k == 7));
      chk("t3_lat7_pending", 128'(q_rc_pending), 128'(k < 7));
    end

    // Flush drops only the incoming packet B, and packet A continues.
    q_ra_addr = 7'd31;
    q_rb_addr = 7'd30;
    send(7'd30, 128'hAAAA, 3'd1);
    tick();
    send(7'd31, 128'hBBBB, 3'd1);
    flush = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      in_wrt_en = 1'b0;
      flush     = 1'b0;
      chk("t4_b_hit", 128'(q_ra_hit), 128'(0));
      chk("t4_b_pending", 128'(q_ra_pending), 128'(0));
      chk("t4_a_hit", 128'(q_rb_hit), 128'(k <= 7));
      chk("t4_wb_en", 128'(wb_en), 128'(k == 7));
      chk("t4_wb_rt", 128'(wb_rt_address), (k == 7) ? 128'd30 : 128'd0);
    end

    // Reset in mid-flight clears the pipe without a clock edge.
    q_ra_addr = 7'd40; q_rb_addr = 7'd41; q_rc_addr = 7'd42;
    send(7'd40, 128'h40, 3'd6); tick();
    send(7'd41, 128'h41, 3'd6); tick();
    send(7'd42, 128'h42, 3'd6); tick();
    in_wrt_en = 1'b0;
    chk("t5_pre_pending", 128'(q_ra_pending), 128'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_wb_en", 128'(wb_en), 128'(0));
    chk("t5_ra_pending", 128'(q_ra_pending), 128'(0));
    chk("t5_rb_pending", 128'(q_rb_pending), 128'(0));
    chk("t5_rc_pending", 128'(q_rc_pending), 128'(0));
    chk("t5_hits", 128'({q_ra_hit, q_rb_hit, q_rc_hit}), 128'(0));
    tick(); tick();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t5_post_wb_en", 128'(wb_en), 128'(0));
      chk("t5_post_pending", 128'({q_ra_pending, q_rb_pending, q_rc_pending}), 128'(0));
    end

    // Randomised traffic with a small address space so that matches are frequent.
    for (int c = 0; c < 600; c++) begin
      tick();
      in_wrt_en     = ($urandom_range(0, 3) != 0);
      in_rt_address = 7'($urandom_range(0, 15));
      in_value      = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_latency    = 3'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 7) == 0);
      q_ra_addr     = 7'($urandom_range(0, 15));
      q_rb_addr     = 7'($urandom_range(0, 15));
      q_rc_addr     = 7'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
      end
    end
    in_wrt_en = 1'b0;
    flush     = 1'b0;
    repeat (DEPTH + 1) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/odd_result_pipe.md
Name: odd_result_pipe

Overview:
- Downstream of the odd pipe (permute, load/store, branch units); consumes its per-instruction result packets.
- Holds each result in a fixed-depth delay line until the common writeback point.
- The producing unit's latency sets when a result becomes forwardable.
- Provides ra/rb/rc operand-forwarding lookup with a pending (stall) indication, plus the register-file writeback port.

Parameters:
- DEPTH, 7: number of delay stages; writeback is taken from stage DEPTH.
- FLUSH_STAGES, 1: number of youngest stages (1..FLUSH_STAGES) invalidated by flush.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_wrt_en  input  1  result packet is valid and writes a register.
- in_rt_address  input  7  destination register.
- in_value  input  128  result data.
- in_latency  input  3  unit latency: permute 4, load 6, branch-link 1.
- flush  input  1  branch redirect; kills young entries.
- q_ra_addr, q_rb_addr, q_rc_addr  input  7 each  operand lookup addresses.
- q_ra_hit, q_rb_hit, q_rc_hit  output  1 each  ready forwarded value available.
- q_ra_value, q_rb_value, q_rc_value  output  128 each  forwarded data, 0 when no hit.
- q_ra_pending, q_rb_pending, q_rc_pending  output  1 each  youngest match is not yet ready; the issue stage must stall.
- wb_en  output  1  register-file write enable.
- wb_rt_address  output  7  writeback destination.
- wb_value  output  128  writeback data.

Behaviour:
- Each stage s (1..DEPTH) is a register holding {valid, rt_address[7], value[128], latency[3]}.
- Every rising edge, with no flush:
  - stage 1 <= input packet, valid = in_wrt_en.
  - stage s <= stage s-1 for s = 2..DEPTH.
  - The stage-DEPTH entry retires.
- There is no stall or backpressure; the pipe always advances.
- Latency normalisation at capture:
  - 0 is stored as 1.
  - Any value greater than DEPTH is stored as DEPTH.
- An entry in stage s is ready when s >= stored latency.
- Writeback outputs are combinational from stage DEPTH:
  - wb_en = valid.
  - wb_rt_address and wb_value are the stage's fields.
  - All wb_* outputs are 0 when stage DEPTH is invalid.
- Result latency: a packet presented before edge N appears on the wb_* outputs after edge N+DEPTH-1. With DEPTH=7 that is 7 edges after capture, counting the capture edge.
- Forwarding, evaluated independently for each query port, combinationally over stages 1..DEPTH:
  - The youngest valid entry whose address matches decides the result. Youngest means the lowest stage number.
  - If that entry is ready: hit=1, value=entry value, pending=0.
  - If it is not ready: hit=0, value=0, pending=1. Older ready matches are ignored, because they hold stale data.
  - With no match: hit=0, pending=0, value=0.
  - The un-registered input packet does not participate in forwarding.
- Flush (sampled on the rising edge):
  - Stages 1..FLUSH_STAGES load valid=0, so the incoming packet is also dropped.
  - Deeper stages shift normally.
  - With FLUSH_STAGES=1, the packet in stage 1 still moves to stage 2, and only the incoming packet is dropped.
  - General rule: after the edge, stages 1..FLUSH_STAGES are invalid; every stage s > FLUSH_STAGES holds the old stage s-1.
- Reset (asserted low, asynchronous):
  - All valid bits, addresses, values and latencies clear immediately. This includes reset in the middle of operation.
  - All outputs read 0 while reset is held.
  - On release, the pipe resumes empty on the next edge.
- Same address in consecutive cycles: both entries are kept and both write back in order. The later write wins in the register file.

Test Plan:
- Basic writeback (DEPTH=7): one packet {wrt_en=1, rt=5, value=0xA5A5, latency=4}, then idle.
  - Required: wb_en=1, rt=5, value=0xA5A5 exactly 7 edges after capture.
  - Required: wb_en=0 in all other cycles.
- Readiness window: same packet as above, q_ra_addr=5.
  - Required: pending=1 and hit=0 while the entry is in stages 1-3.
  - Required: hit=1 with value 0xA5A5 while it is in stages 4-7.
  - Required: hit=0 and pending=0 after it retires.
- Youngest-wins stale block:
  - Stimulus: rt=9 value=0x1 latency=1, then the next cycle rt=9 value=0x2 latency=6, with q_rb_addr=9.
  - Required: while the newer entry is in stages 1-5, pending=1 and hit=0, even though the older entry is ready.
  - Required: from stage 6 on, hit=1 with value=0x2.
- Latency clamp: latency=0 gives hit=1 while the entry is in stage 1; latency=7 gives hit only in stage 7.
- Flush (FLUSH_STAGES=1):
  - Stimulus: packet A captured, then packet B presented with flush=1 on the next edge.
  - Required: A continues and writes back.
  - Required: B never appears on wb_* or on forwarding outputs.
- Reset mid-flight:
  - Stimulus: three packets in flight, then reset driven low between edges.
  - Required: wb_en and all hit/pending outputs drop to 0 immediately, with no clock edge needed.
  - Required: after reset is released, no stale writeback occurs.
